// File: rtl/wide_comp_pkg.sv
// rtl/wide_comp_pkg.sv - shared types, result encoding and cascade resolve for wide_comp_seq
// Contents:
//   state_t          controller states (IDLE, RUN, DONE)
//   RES_L/EQ/G       3-bit one-hot result encoding, bit order {L, EQ, G}
//   cascade_resolve  turns the cascade bits into a result when all nibbles are equal
package wide_comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_L  = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_G  = 3'b001;

    // Priority great > less > equal; no cascade bit set still means equal.
    function automatic logic [2:0] cascade_resolve(input logic great,
                                                   input logic equal,
                                                   input logic less);
        logic [2:0] r;
        r = RES_EQ;
        if (great)
            r = RES_G;
        else if (less)
            r = RES_L;
        else if (equal)
            r = RES_EQ;
        return r;
    endfunction

endpackage

// File: rtl/wide_comp_seq_nibble_comp.sv
// rtl/wide_comp_seq_nibble_comp.sv - combinational 4-bit magnitude compare with cascade in/out
// Ports:
//   i_a, i_b            nibbles to compare
//   i_gt, i_eq, i_lt    cascade in: decision already made by more significant nibbles
//   o_gt, o_eq, o_lt    cascade out: decision including this nibble
module nibble_comp (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_gt,
    input  logic       i_eq,
    input  logic       i_lt,
    output logic       o_gt,
    output logic       o_eq,
    output logic       o_lt
);

    // A decision from a more significant nibble always wins over this one.
    always_comb begin
        o_gt = 1'b0;
        o_eq = 1'b0;
        o_lt = 1'b0;
        if (i_gt)
            o_gt = 1'b1;
        else if (i_lt)
            o_lt = 1'b1;
        else if (i_a > i_b)
            o_gt = 1'b1;
        else if (i_a < i_b)
            o_lt = 1'b1;
        else
            o_eq = i_eq;
    end

endmodule

// File: rtl/wide_comp_seq.sv
// rtl/wide_comp_seq.sv - multi-cycle WIDTH-bit magnitude comparator, one nibble per cycle, MSB first
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start_valid / start_ready     operand handshake (a, b, great, equal, less sampled on it)
//   res_valid / res_ready         result handshake
//   L, EQ, G                      registered one-hot result
//   busy                          high while comparing
// Build option: WIDE_COMP_EARLY_EXIT_EN - leave RUN as soon as a nibble differs.
module wide_comp_seq
    import wide_comp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             great,
    input  logic             equal,
    input  logic             less,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             L,
    output logic             EQ,
    output logic             G,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_great;
    logic             r_equal;
    logic             r_less;
    logic [IDX_W-1:0] r_idx;
    logic             r_gt;
    logic             r_lt;
    logic [2:0]       r_res;
    logic             r_start_ready;
    logic             r_busy;
    logic             r_res_valid;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;
    logic             w_exit;

    assign w_nib_a = r_a[{r_idx, 2'b00} +: 4];
    assign w_nib_b = r_b[{r_idx, 2'b00} +: 4];

    // Running decision from the nibbles already visited feeds the cascade input.
    nibble_comp u_nibble_comp (
        .i_a  (w_nib_a),
        .i_b  (w_nib_b),
        .i_gt (r_gt),
        .i_eq (~(r_gt | r_lt)),
        .i_lt (r_lt),
        .o_gt (w_gt),
        .o_eq (w_eq),
        .o_lt (w_lt)
    );

`ifdef WIDE_COMP_EARLY_EXIT_EN
    assign w_exit = (r_idx == '0) || !w_eq;
`else
    assign w_exit = (r_idx == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_great       <= 1'b0;
            r_equal       <= 1'b0;
            r_less        <= 1'b0;
            r_idx         <= '0;
            r_gt          <= 1'b0;
            r_lt          <= 1'b0;
            r_res         <= '0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_a           <= a;
                        r_b           <= b;
                        r_great       <= great;
                        r_equal       <= equal;
                        r_less        <= less;
                        r_idx         <= IDX_LAST;
                        r_gt          <= 1'b0;
                        r_lt          <= 1'b0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_gt <= w_gt;
                    r_lt <= w_lt;
                    if (w_exit) begin
                        if (w_gt)
                            r_res <= RES_G;
                        else if (w_lt)
                            r_res <= RES_L;
                        else
                            r_res <= cascade_resolve(r_great, r_equal, r_less);
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    // start_ready rises only after this edge, forcing one idle cycle.
                    if (res_ready) begin
                        r_res_valid   <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_start_ready <= 1'b1;
                    r_busy        <= 1'b0;
                    r_res_valid   <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign L           = r_res[2];
    assign EQ          = r_res[1];
    assign G           = r_res[0];

endmodule
